// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and frame constants for the UART transmitter and receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter that pulses tick_o on the last cycle of each bit
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Count while enabled, wrap on each bit boundary, park at zero when disabled
    always_comb begin
        cnt_d = !en_i ? '0 : tick_o ? '0 : cnt_q + CW'(1);
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 / 8E1 UART transmitter with a one-entry holding register in front of the shifter
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       txd_o,
    output logic       busy_o
);

    uart_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        txd_q, txd_d;
    logic        tick, accept, move, last_bit, data_step;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (state_q != ST_IDLE),
        .tick_o (tick)
    );

    assign ready_o   = !hold_full_q;
    assign busy_o    = (state_q != ST_IDLE) || hold_full_q;
    assign txd_o     = txd_q;
    assign accept    = valid_i && !hold_full_q;
    assign move      = hold_full_q && ((state_q == ST_IDLE) || (state_q == ST_STOP && tick));
    assign last_bit  = bit_idx_q == 3'(DATA_BITS - 1);
    assign data_step = (state_q == ST_DATA) && tick;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: every bit phase ends on a baud tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = hold_full_q ? ST_START : ST_IDLE;
            ST_START:  state_d = tick ? ST_DATA : ST_START;
            ST_DATA:   state_d = (tick && last_bit) ? (PARITY_EN ? ST_PARITY : ST_STOP) : ST_DATA;
            ST_PARITY: state_d = tick ? ST_STOP : ST_PARITY;
            ST_STOP:   state_d = tick ? (hold_full_q ? ST_START : ST_IDLE) : ST_STOP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Line output for the current state, registered so txd_o lags the state by one cycle
    always_comb begin
        txd_d = (state_q == ST_START)  ? START_BIT :
                (state_q == ST_DATA)   ? shift_q[0] :
                (state_q == ST_PARITY) ? parity_q : STOP_BIT;
    end

    // Holding register, shifter, parity and bit index; accept only ever happens into an empty holder
    always_comb begin
        hold_full_d = accept || (hold_full_q && !move);
        hold_d      = accept ? data_i : hold_q;
        shift_d     = move ? hold_q : data_step ? (shift_q >> 1) : shift_q;
        parity_d    = move ? even_parity(hold_q) : parity_q;
        bit_idx_d   = move ? 3'd0 : data_step ? bit_idx_q + 3'd1 : bit_idx_q;
    end

    // Datapath registers; reset drops the held byte and returns the line to idle at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_idx_q   <= '0;
            txd_q       <= STOP_BIT;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_idx_q   <= bit_idx_d;
            txd_q       <= txd_d;
        end
    end

endmodule
